// File: rtl/updown_count_monitor.sv
// updown_count_monitor: infers direction/pause/lock of a 4-bit up/down counter and flags illegal steps (err_cnt enabled by UPDOWN_MON_ERRCNT_EN)
module updown_count_monitor #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Q,
  output logic       dir_up,
  output logic       paused,
  output logic       locked,
  output logic       step_err,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
  localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);
  state_t state, state_n;
  logic [3:0] q_prev, run, run_n, delta;
  logic dir_up_n, paused_n, locked_n, step_err_n, mv_up, mv_dn, hold, illegal;
  // classify the step from the previous sample, modulo 16 so wrap-around is legal
  always_comb begin
    delta = Q - q_prev;
    mv_up = delta == 4'd1;
    mv_dn = delta == 4'hf;
    hold = delta == 4'd0;
    illegal = !(mv_up || mv_dn || hold);
  end
  // next-state and next-output decode; IDLE only arms the monitor
  always_comb begin
    state_n = state;
    run_n = run;
    dir_up_n = dir_up;
    paused_n = paused;
    locked_n = locked;
    step_err_n = step_err;
    if (state == IDLE) state_n = TRACK;
    else if (illegal) begin
      step_err_n = 1'b1;
      locked_n = 1'b0;
      state_n = TRACK;
      run_n = '0;
    end else begin
      step_err_n = 1'b0;
      if (hold) paused_n = 1'b1;
      else begin
        dir_up_n = mv_up;
        paused_n = 1'b0;
        run_n = (mv_up != dir_up) ? 4'd1 : (run == 4'hf ? run : run + 4'd1);
        if (state == TRACK && run_n >= LOCK_RUN) state_n = LOCKED;
        locked_n = state_n == LOCKED;
      end
    end
  end
  // state and registered outputs; reset wins over any step on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q_prev <= '0;
      run <= '0;
      dir_up <= 1'b0;
      paused <= 1'b0;
      locked <= 1'b0;
      step_err <= 1'b0;
    end else begin
      state <= state_n;
      q_prev <= Q;
      run <= run_n;
      dir_up <= dir_up_n;
      paused <= paused_n;
      locked <= locked_n;
      step_err <= step_err_n;
    end
  end
`ifdef UPDOWN_MON_ERRCNT_EN
  // saturating count of illegal steps, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) err_cnt <= '0;
    else if (state != IDLE && illegal && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_updown_count_monitor.sv
// tb_updown_count_monitor: directed and random checks of two monitors (LOCK_CNT 3 and 1) against an arithmetic model
module tb_updown_count_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] Q = '0;
  logic dir_up [2];
  logic paused [2];
  logic locked [2];
  logic step_err [2];
  logic [7:0] err_cnt [2];
  int errors = 0;
  int checks = 0;
  int lock_of [2] = '{3, 1};
  bit m_armed [2];
  int m_prev [2], m_run [2], m_cnt [2];
  bit m_dir [2], m_paused [2], m_locked [2], m_err [2];
  logic [3:0] last_q = '0;

  always #5 clk = ~clk;

  updown_count_monitor #(.LOCK_CNT(3)) dut0 (
    .clk(clk), .reset(reset), .Q(Q), .dir_up(dir_up[0]), .paused(paused[0]),
    .locked(locked[0]), .step_err(step_err[0]), .err_cnt(err_cnt[0])
  );
  updown_count_monitor #(.LOCK_CNT(1)) dut1 (
    .clk(clk), .reset(reset), .Q(Q), .dir_up(dir_up[1]), .paused(paused[1]),
    .locked(locked[1]), .step_err(step_err[1]), .err_cnt(err_cnt[1])
  );

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[lock=%0d] observed=%0h expected=%0h at t=%0t", tag, lock_of[k], obs, exp, $time);
    end
  endtask

  task automatic model(input int k, input int q, input bit r);
    int d;
    bit up;
    if (r) begin
      m_armed[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
      m_dir[k] = 0; m_paused[k] = 0; m_locked[k] = 0; m_err[k] = 0;
    end else if (!m_armed[k]) begin
      m_armed[k] = 1;
      m_prev[k] = q;
    end else begin
      d = (q - m_prev[k] + 16) % 16;
      m_prev[k] = q;
      if (d == 0) begin
        m_paused[k] = 1; m_err[k] = 0;
      end else if (d == 1 || d == 15) begin
        up = (d == 1);
        m_run[k] = (up == m_dir[k]) ? ((m_run[k] + 1 > 15) ? 15 : m_run[k] + 1) : 1;
        m_dir[k] = up; m_paused[k] = 0; m_err[k] = 0;
        if (m_run[k] >= lock_of[k]) m_locked[k] = 1;
      end else begin
        m_err[k] = 1; m_locked[k] = 0; m_run[k] = 0;
`ifdef UPDOWN_MON_ERRCNT_EN
        if (m_cnt[k] < 255) m_cnt[k]++;
`endif
      end
    end
  endtask

  task automatic step(input logic [3:0] q, input bit r);
    Q = q;
    reset = r;
    last_q = q;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model(k, int'(q), r);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("dir_up", k, 8'(dir_up[k]), 8'(m_dir[k]));
      chk("paused", k, 8'(paused[k]), 8'(m_paused[k]));
      chk("locked", k, 8'(locked[k]), 8'(m_locked[k]));
      chk("step_err", k, 8'(step_err[k]), 8'(m_err[k]));
      chk("err_cnt", k, err_cnt[k], 8'(m_cnt[k]));
    end
  endtask

  initial begin
    logic [3:0] nq;
    int sel;
    step(4'd0, 1);
    step(4'd0, 1);
    for (int i = 0; i <= 3; i++) step(4'(i), 0);
    chk("lock_after_3", 0, 8'(locked[0]), 8'd1);
    for (int i = 4; i <= 15; i++) step(4'(i), 0);
    step(4'd0, 0);
    chk("lock_across_wrap", 0, 8'(locked[0]), 8'd1);
    step(4'd1, 0);
    step(4'd0, 0);
    step(4'd15, 0);
    step(4'd14, 0);
    chk("dir_down", 0, 8'(dir_up[0]), 8'd0);
    for (int i = 13; i >= 5; i--) step(4'(i), 0);
    for (int i = 0; i < 3; i++) step(4'd5, 0);
    chk("paused_hold", 0, 8'(paused[0]), 8'd1);
    step(4'd6, 0);
    step(4'd5, 0);
    step(4'd4, 0);
    step(4'd9, 0);
    chk("jump_err", 0, 8'(step_err[0]), 8'd1);
    for (int i = 10; i <= 12; i++) step(4'(i), 0);
    chk("relock", 0, 8'(locked[0]), 8'd1);
    for (int i = 0; i < 300; i++) step((i % 2) ? 4'd8 : 4'd0, 0);
    for (int i = 1; i <= 3; i++) step(4'(i), 0);
    step(4'd9, 1);
    chk("reset_over_err", 0, 8'(step_err[0]), 8'd0);
    step(4'd5, 0);
    step(4'd6, 0);
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(9));
      nq = (sel < 2) ? last_q : (sel < 5) ? last_q + 4'd1 : (sel < 8) ? last_q - 4'd1 : 4'($urandom_range(15));
      step(nq, $urandom_range(39) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
